// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard for the 2R/1W register file: tracks pending writes, stalls RAW/WAW hazards, owns the write port.
// Optional same-cycle writeback forwarding select outputs are enabled by defining REGFILE_SCOREBOARD_FWD_EN.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int SCW   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rs1,
    input  logic             issue_rs1_used,
    input  logic [AW-1:0]    issue_rs2,
    input  logic             issue_rs2_used,
    input  logic [AW-1:0]    issue_rd,
    input  logic             issue_rd_we,
    output logic             issue_ready,
    output logic             stall,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [DW-1:0]    wb_data,
    output logic             rf_we,
    output logic [AW-1:0]    rf_rd,
    output logic [DW-1:0]    rf_wb_data,
    output logic [NREGS-1:0] busy,
`ifdef REGFILE_SCOREBOARD_FWD_EN
    output logic             fwd_rs1_sel,
    output logic             fwd_rs2_sel,
`endif
    output logic [SCW-1:0]   stall_cycles
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [SCW-1:0]   stall_cycles_q, stall_cycles_d;
    logic             raw1, raw2, waw, fire, fwd1, fwd2;

    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`ifdef REGFILE_SCOREBOARD_FWD_EN
        fwd1 = wb_valid && (wb_rd == issue_rs1) && (issue_rs1 != '0) && issue_rs1_used;
        fwd2 = wb_valid && (wb_rd == issue_rs2) && (issue_rs2 != '0) && issue_rs2_used;
`endif
        raw1 = issue_rs1_used && (issue_rs1 != '0) && busy_q[issue_rs1] && !fwd1;
        raw2 = issue_rs2_used && (issue_rs2 != '0) && busy_q[issue_rs2] && !fwd2;
        // A writeback retiring rd this cycle frees the slot for the new writer.
        waw  = issue_rd_we && (issue_rd != '0) && busy_q[issue_rd]
               && !(wb_valid && (wb_rd == issue_rd));
    end

    assign issue_ready = !(raw1 || raw2 || waw) && !flush;
    assign stall       = issue_valid && !issue_ready;
    assign fire        = issue_valid && issue_ready;

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_valid)
                busy_d[wb_rd] = 1'b0;
            // Set after clear so a same-cycle issue of rd keeps it pending.
            if (fire && issue_rd_we && (issue_rd != '0))
                busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {SCW{1'b1}}))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q         <= '0;
            stall_cycles_q <= '0;
        end else begin
            busy_q         <= busy_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign rf_we        = wb_valid && (wb_rd != '0) && !flush;
    assign rf_rd        = wb_rd;
    assign rf_wb_data   = wb_data;
    assign busy         = busy_q;
    assign stall_cycles = stall_cycles_q;
`ifdef REGFILE_SCOREBOARD_FWD_EN
    assign fwd_rs1_sel  = fwd1;
    assign fwd_rs2_sel  = fwd2;
`endif

endmodule
